// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding and the starvation-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    // Counter must hold 0..STARVE_LIMIT inclusive.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: data wins unless fetch has waited through
// STARVE_LIMIT consecutive data grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = starve_cnt_w(STARVE_LIMIT)
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i,
    output logic             grant_d
);

    logic fetch_forced;

    always_comb begin
        fetch_forced = i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_d      = d_req && !fetch_forced;
        grant_i      = i_req && !grant_d;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction
// fetch and data load/store, with per-stage stall outputs.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              if_stall,
    output logic              mem_stall
);

    localparam int               CNT_W   = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              grant_i, grant_d;
    logic              ack_i, ack_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d   = D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    // Only data grants that leave fetch waiting count as starvation.
                    if (i_req) begin
                        starve_d = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + CNT_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (grant_i) begin
                    state_d   = I_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    starve_d  = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Completion is combinational from m_ack so the winner sees data in the ack cycle.
    assign ack_i     = (state_q == I_BUSY) && m_ack;
    assign ack_d     = (state_q == D_BUSY) && m_ack;
    assign i_ready   = ack_i;
    assign d_ready   = ack_d;
    assign i_rdata   = ack_i ? m_rdata : '0;
    assign d_rdata   = ack_d ? m_rdata : '0;
    assign if_stall  = i_req && !ack_i;
    assign mem_stall = d_req && !ack_d;

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and a unified memory.
module tb_unified_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, m_req, m_we, if_stall, mem_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    // Memory seen on the m_* pins, and the reference memory the model expects.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Transaction-level model: one outstanding access, winner and starvation count.
    bit          mdl_busy, mdl_port_d, mdl_we;
    logic [31:0] mdl_addr, mdl_wdata;
    int          mdl_cnt, mdl_lat, mdl_starve, fixed_lat;
    bit          exp_i_ready, exp_d_ready;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic model_reset();
        mdl_busy   = 0;
        mdl_cnt    = 0;
        mdl_starve = 0;
    endtask

    // Drive the memory response for the current cycle and derive expectations.
    task automatic settle();
        m_ack = mdl_busy && (mdl_cnt + 1 == mdl_lat);
        if (m_ack && !(mdl_port_d && mdl_we)) m_rdata = mem_rd(m_addr);
        else m_rdata = $urandom;
        #1;
        exp_i_ready = m_ack && !mdl_port_d;
        exp_d_ready = m_ack && mdl_port_d;
    endtask

    // Advance the model over the coming edge, then wait for it.
    task automatic tick();
        if (mdl_busy) begin
            if (m_ack) begin
                if (mdl_port_d && mdl_we) begin
                    mem[m_addr]       = m_wdata;
                    ref_mem[mdl_addr] = mdl_wdata;
                end
                mdl_busy = 0;
            end else begin
                mdl_cnt++;
            end
        end else if (i_req || d_req) begin
            mdl_port_d = d_req && !(i_req && mdl_starve == LIM);
            if (mdl_port_d && i_req) mdl_starve = (mdl_starve < LIM) ? mdl_starve + 1 : LIM;
            else mdl_starve = 0;
            mdl_busy  = 1;
            mdl_cnt   = 0;
            mdl_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            mdl_addr  = mdl_port_d ? d_addr : i_addr;
            mdl_we    = mdl_port_d && d_we;
            mdl_wdata = mdl_port_d ? d_wdata : 32'h0;
        end
        @(posedge clk);
        #1;
        m_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ack = 1'b1;
        m_rdata = $urandom;
        #2;
        checks++;
        if ({m_req, m_we, i_ready, d_ready, if_stall, mem_stall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: m_req/m_we/i_ready/d_ready/if_stall/mem_stall=%b required 000000",
                     {m_req, m_we, i_ready, d_ready, if_stall, mem_stall});
        end
        checks++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mport: m_addr=%h m_wdata=%h required 0 0", m_addr, m_wdata);
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h required 0 0", i_rdata, d_rdata);
        end
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fetch();
        int stall = 0;
        fixed_lat = 1;
        preload(32'h40, 32'h8C01_0004);
        i_req = 1'b1;
        i_addr = 32'h40;
        settle();
        if (if_stall) stall++;
        checks++;
        if (m_req !== 1'b0 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL fetch_req_cycle: m_req=%b i_ready=%b required 0 0", m_req, i_ready);
        end
        tick();
        settle();
        if (if_stall) stall++;
        checks++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h40}) begin
            failures++;
            $display("FAIL fetch_mport: m_req=%b m_we=%b m_addr=%h required 1 0 00000040", m_req, m_we, m_addr);
        end
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h8C01_0004 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL fetch_data: i_ready=%b i_rdata=%h d_ready=%b required 1 8c010004 0", i_ready, i_rdata, d_ready);
        end
        tick();
        i_req = 1'b0;
        settle();
        checks++;
        if (m_req !== 1'b0 || i_ready !== 1'b0 || i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_after: m_req=%b i_ready=%b i_rdata=%h required 0 0 0", m_req, i_ready, i_rdata);
        end
        checks++;
        if (stall != 1) begin
            failures++;
            $display("FAIL fetch_stall_len: if_stall cycles=%0d required 1", stall);
        end
        tick();
    endtask

    task automatic test_store();
        int stall = 0, readies = 0, busy = 0;
        bit saw;
        fixed_lat = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 12 && d_req; c++) begin
            settle();
            if (mem_stall) stall++;
            if (d_ready) readies++;
            if (m_req) begin
                busy++;
                checks++;
                if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
                    failures++;
                    $display("FAIL store_mport: m_we=%b m_addr=%h m_wdata=%h required 1 00000100 deadbeef",
                             m_we, m_addr, m_wdata);
                end
            end
            saw = d_ready;
            tick();
            if (saw) d_req = 1'b0;
        end
        checks++;
        if (d_req !== 1'b0 || readies != 1) begin
            failures++;
            $display("FAIL store_ready: d_ready pulses=%0d required 1", readies);
        end
        checks++;
        if (stall != 3 || busy != 3) begin
            failures++;
            $display("FAIL store_timing: mem_stall cycles=%0d m_req cycles=%0d required 3 3", stall, busy);
        end
        settle();
        checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL store_release: m_req=%b m_we=%b d_ready=%b required 0 0 0", m_req, m_we, d_ready);
        end
        tick();
    endtask

    task automatic test_load();
        logic [31:0] addrs [2];
        logic [31:0] vals  [2];
        logic [31:0] exp_d;
        int readies;
        bit saw;
        addrs[0] = 32'h200; vals[0] = 32'h1234_5678;
        addrs[1] = 32'h100; vals[1] = 32'hDEAD_BEEF;
        preload(32'h200, 32'h1234_5678);
        fixed_lat = 2;
        for (int k = 0; k < 2; k++) begin
            readies = 0;
            d_req = 1'b1; d_we = 1'b0; d_addr = addrs[k]; d_wdata = $urandom;
            for (int c = 0; c < 10 && d_req; c++) begin
                settle();
                exp_d = d_ready ? vals[k] : 32'h0;
                if (d_ready) readies++;
                checks++;
                if (i_ready !== 1'b0 || i_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL load_iport_quiet: i_ready=%b i_rdata=%h required 0 0", i_ready, i_rdata);
                end
                checks++;
                if (d_rdata !== exp_d) begin
                    failures++;
                    $display("FAIL load_rdata: addr=%h d_ready=%b d_rdata=%h required %h", addrs[k], d_ready, d_rdata, exp_d);
                end
                saw = d_ready;
                tick();
                if (saw) d_req = 1'b0;
            end
            checks++;
            if (readies != 1 || d_req !== 1'b0) begin
                failures++;
                $display("FAIL load_ready: addr=%h d_ready pulses=%0d required 1", addrs[k], readies);
            end
        end
    endtask

    task automatic test_both();
        string order = "";
        int i_done = -1;
        bit saw_i, saw_d;
        fixed_lat = 1;
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 0; c < 12 && (i_req || d_req); c++) begin
            settle();
            if (d_ready) begin
                order = {order, "D"};
                checks++;
                if (d_rdata !== ref_rd(32'h300)) begin
                    failures++;
                    $display("FAIL both_drdata: d_rdata=%h required %h", d_rdata, ref_rd(32'h300));
                end
            end
            if (i_ready) begin
                order = {order, "I"};
                i_done = c;
                checks++;
                if (i_rdata !== ref_rd(32'h80)) begin
                    failures++;
                    $display("FAIL both_irdata: i_rdata=%h required %h", i_rdata, ref_rd(32'h80));
                end
            end
            saw_i = i_ready; saw_d = d_ready;
            tick();
            if (saw_i) i_req = 1'b0;
            if (saw_d) d_req = 1'b0;
        end
        checks++;
        if (order != "DI" || i_done != 3) begin
            failures++;
            $display("FAIL both_order: order=%s fetch_done_cycle=%0d required DI 3", order, i_done);
        end
    endtask

    task automatic test_starvation();
        string order = "";
        int fetch_done = -1, stall_if = 0, d_after = 0;
        bit saw_i, saw_d;
        fixed_lat = 1;
        i_req = 1'b1; i_addr = 32'hC0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int c = 0; c < 30 && d_req; c++) begin
            settle();
            if (if_stall) stall_if++;
            checks++;
            if (i_ready && d_ready) begin
                failures++;
                $display("FAIL starve_one_ready: i_ready=%b d_ready=%b required at most one", i_ready, d_ready);
            end
            if (d_ready) begin
                order = {order, "D"};
                if (fetch_done >= 0) d_after++;
            end
            if (i_ready) begin
                order = {order, "I"};
                fetch_done = c;
            end
            saw_i = i_ready; saw_d = d_ready;
            tick();
            if (saw_i) i_req = 1'b0;
            if (saw_d) begin
                if (d_after >= 1) d_req = 1'b0;
                else d_addr = d_addr + 32'h4;
            end
        end
        checks++;
        if (order != "DDDDID") begin
            failures++;
            $display("FAIL starve_order: order=%s required DDDDID", order);
        end
        checks++;
        if (fetch_done != 9 || stall_if != 9) begin
            failures++;
            $display("FAIL starve_latency: fetch_done_cycle=%0d if_stall cycles=%0d required 9 9", fetch_done, stall_if);
        end
    endtask

    task automatic test_reset_mid();
        int readies = 0;
        bit saw;
        fixed_lat = 5;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hA5A5_0F0F;
        settle();
        tick();
        settle();
        tick();
        m_ack = 1'b1;
        m_rdata = $urandom;
        #1;
        checks++;
        if (m_req !== 1'b1 || d_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: m_req=%b d_ready=%b required 1 1", m_req, d_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_req, m_we, i_ready, d_ready} !== 4'b0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_async: m_req/m_we/i_ready/d_ready=%b d_rdata=%h required 0000 0",
                     {m_req, m_we, i_ready, d_ready}, d_rdata);
        end
        m_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        checks++;
        if (m_req !== 1'b0 || mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_idle: m_req=%b mem_stall=%b required 0 1", m_req, mem_stall);
        end
        tick();
        for (int c = 0; c < 12 && d_req; c++) begin
            settle();
            checks++;
            if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h400, 32'hA5A5_0F0F}) begin
                failures++;
                $display("FAIL rstmid_regrant: m_req=%b m_we=%b m_addr=%h m_wdata=%h required 1 1 00000400 a5a50f0f",
                         m_req, m_we, m_addr, m_wdata);
            end
            if (d_ready) readies++;
            saw = d_ready;
            tick();
            if (saw) d_req = 1'b0;
        end
        checks++;
        if (readies != 1 || d_req !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_complete: d_ready pulses=%0d required 1", readies);
        end
    endtask

    task automatic test_random();
        bit saw_i, saw_d;
        logic [4:0]  exp_ctrl;
        logic [31:0] exp_i, exp_d;
        fixed_lat = 0;
        for (int c = 0; c < 600; c++) begin
            settle();
            exp_ctrl = {mdl_busy, exp_i_ready, exp_d_ready, i_req && !exp_i_ready, d_req && !exp_d_ready};
            checks++;
            if ({m_req, i_ready, d_ready, if_stall, mem_stall} !== exp_ctrl) begin
                failures++;
                $display("FAIL rnd_ctrl: cycle=%0d m_req/i_ready/d_ready/if_stall/mem_stall=%b required %b",
                         c, {m_req, i_ready, d_ready, if_stall, mem_stall}, exp_ctrl);
            end
            checks++;
            if (mdl_busy ? ({m_we, m_addr, m_wdata} !== {mdl_we, mdl_addr, mdl_wdata}) : (m_we !== 1'b0)) begin
                failures++;
                $display("FAIL rnd_mport: cycle=%0d m_we=%b m_addr=%h m_wdata=%h required %b %h %h (busy=%0d)",
                         c, m_we, m_addr, m_wdata, mdl_busy && mdl_we, mdl_addr, mdl_wdata, mdl_busy);
            end
            exp_i = exp_i_ready ? ref_rd(mdl_addr) : 32'h0;
            checks++;
            if (i_rdata !== exp_i) begin
                failures++;
                $display("FAIL rnd_irdata: cycle=%0d i_rdata=%h required %h", c, i_rdata, exp_i);
            end
            if (!(exp_d_ready && mdl_we)) begin
                exp_d = exp_d_ready ? ref_rd(mdl_addr) : 32'h0;
                checks++;
                if (d_rdata !== exp_d) begin
                    failures++;
                    $display("FAIL rnd_drdata: cycle=%0d d_rdata=%h required %h", c, d_rdata, exp_d);
                end
            end
            saw_i = exp_i_ready; saw_d = exp_d_ready;
            tick();
            if (!i_req || saw_i) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 31)) << 2;
            end
            if (!d_req || saw_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'($urandom_range(0, 31)) << 2;
                d_wdata = $urandom;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        fixed_lat = 1;
        model_reset();
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_both();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
